parking_request_queue: RTL and testbench

Upstream front end of the parking-lot controller. Captures single-cycle in/out requests (with license plate) and leakage alarms, validates them, and buffers them. Presents one pending task at a time on the todo_* interface consumed by the elevator/slot-allocation stage. Leakage tasks always pre-empt queued in/out requests.

---
 rtl/parking_pkg.sv | 20 ++
 rtl/parking_req_fifo.sv | 69 ++++++
 rtl/parking_request_queue.sv | 127 ++++++++++++
 tb/tb_parking_request_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants and helpers for the parking-lot request front end.
// Task kinds, the floor count, and the BCD plate check.
package parking_pkg;

  localparam logic [1:0] REQ_IN     = 2'b01;
  localparam logic [1:0] REQ_OUT    = 2'b10;
  localparam int         NUM_FLOORS = 7;
  localparam int         PLATE_W    = 16;

  // A plate is only a legal BCD number if every nibble is a decimal digit.
  function automatic logic bcd_plate_valid(input logic [PLATE_W-1:0] plate);
    logic ok;
    ok = 1'b1;
    for (int n = 0; n < PLATE_W / 4; n++) begin
      if (plate[4*n +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/parking_req_fifo.sv
// Synchronous FIFO with a first-word-fall-through head, used for queued in/out requests.
// A push while full is accepted only when a pop frees the slot on the same edge.
module parking_req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    unique case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is never observed while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/parking_request_queue.sv
// Front end of the parking-lot controller: validates in/out requests and leakage alarms,
// queues them, and presents one task at a time with leakage evacuations taking priority.
module parking_request_queue #(
  parameter int DEPTH   = 8,
  parameter int PLATE_W = parking_pkg::PLATE_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PLATE_W-1:0] license_plate,
  input  logic               in_mode,
  input  logic               out_mode,
  input  logic               leakage,
  input  logic [2:0]         leakage_floor,
  input  logic               todo_done,
  output logic               todo_exists,
  output logic               todo_in,
  output logic               todo_out,
  output logic               todo_leak_move,
  output logic [PLATE_W-1:0] todo_license_plate,
  output logic [2:0]         todo_floor,
  output logic [3:0]         queue_count,
  output logic               overflow,
  output logic               reject
);

  import parking_pkg::*;

  localparam int ENTRY_W = PLATE_W + 2;

  logic [NUM_FLOORS-1:0] leakMask_q, leakMask_d;
  logic                  overflow_q, overflow_d;
  logic                  reject_q, reject_d;

  logic                  reqSeen;
  logic                  reqValid;
  logic [NUM_FLOORS-1:0] leakSet;
  logic [NUM_FLOORS-1:0] leakLowest;
  logic [2:0]            leakFloor;
  logic                  leakPending;
  logic                  leakPop;
  logic                  fifoPush;
  logic                  fifoPop;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [ENTRY_W-1:0]    fifoWdata;
  logic [ENTRY_W-1:0]    fifoHead;
  logic [$clog2(DEPTH):0] fifoCount;

  assign reqSeen  = in_mode || out_mode;
  assign reqValid = reqSeen && !(in_mode && out_mode)
                    && bcd_plate_valid(license_plate) && (license_plate != '0);
  assign fifoPush  = reqValid;
  assign fifoWdata = {(in_mode ? REQ_IN : REQ_OUT), license_plate};

  assign leakPending = (leakMask_q != '0);
  assign leakLowest  = leakMask_q & (-leakMask_q);
  assign leakPop     = todo_done && leakPending;
  assign fifoPop     = todo_done && !leakPending && !fifoEmpty;

  // Lowest set floor wins; scanning downward lets the lowest index overwrite the rest.
  always_comb begin
    leakFloor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (leakMask_q[i]) leakFloor = 3'(i + 1);
    end
  end

  // A new alarm is applied after the pop clear so it is never lost.
  always_comb begin
    leakSet = '0;
    if (leakage && leakage_floor != 3'd0) leakSet[leakage_floor - 3'd1] = 1'b1;
    leakMask_d = (leakMask_q & ~(leakPop ? leakLowest : '0)) | leakSet;
    overflow_d = overflow_q || (fifoPush && fifoFull && !fifoPop);
    reject_d   = (reqSeen && !reqValid) || (leakage && leakage_floor == 3'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leakMask_q <= '0;
      overflow_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      leakMask_q <= leakMask_d;
      overflow_q <= overflow_d;
      reject_q   <= reject_d;
    end
  end

  parking_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i (fifoWdata),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_comb begin
    todo_exists        = 1'b0;
    todo_in            = 1'b0;
    todo_out           = 1'b0;
    todo_leak_move     = 1'b0;
    todo_license_plate = '0;
    todo_floor         = '0;
    if (leakPending) begin
      todo_exists    = 1'b1;
      todo_leak_move = 1'b1;
      todo_floor     = leakFloor;
    end else if (!fifoEmpty) begin
      todo_exists        = 1'b1;
      todo_in            = (fifoHead[ENTRY_W-1 -: 2] == REQ_IN);
      todo_out           = (fifoHead[ENTRY_W-1 -: 2] == REQ_OUT);
      todo_license_plate = fifoHead[PLATE_W-1:0];
    end
  end

  assign queue_count = 4'(fifoCount);
  assign overflow    = overflow_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_parking_request_queue.sv
// Directed self-checking bench for parking_request_queue.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_parking_request_queue;

  logic        clock;
  logic        reset;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;
  logic        leakage;
  logic [2:0]  leakage_floor;
  logic        todo_done;
  logic        todo_exists;
  logic        todo_in;
  logic        todo_out;
  logic        todo_leak_move;
  logic [15:0] todo_license_plate;
  logic [2:0]  todo_floor;
  logic [3:0]  queue_count;
  logic        overflow;
  logic        reject;

  int checks = 0;
  int errors = 0;

  parking_request_queue #(.DEPTH(8), .PLATE_W(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .license_plate      (license_plate),
    .in_mode            (in_mode),
    .out_mode           (out_mode),
    .leakage            (leakage),
    .leakage_floor      (leakage_floor),
    .todo_done          (todo_done),
    .todo_exists        (todo_exists),
    .todo_in            (todo_in),
    .todo_out           (todo_out),
    .todo_leak_move     (todo_leak_move),
    .todo_license_plate (todo_license_plate),
    .todo_floor         (todo_floor),
    .queue_count        (queue_count),
    .overflow           (overflow),
    .reject             (reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushReq(input logic isIn, input logic isOut, input logic [15:0] plate);
    in_mode = isIn; out_mode = isOut; license_plate = plate;
    tick();
    in_mode = 1'b0; out_mode = 1'b0; license_plate = '0;
  endtask

  task automatic popTask();
    todo_done = 1'b1;
    tick();
    todo_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({todo_exists, todo_in, todo_out, todo_leak_move, overflow, reject} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_flags got %b expected 000000",
        {todo_exists, todo_in, todo_out, todo_leak_move, overflow, reject});
    end
    checks++;
    if (queue_count !== 4'd0 || todo_license_plate !== 16'h0 || todo_floor !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_values got count=%0d plate=%h floor=%0d expected 0/0000/0",
        queue_count, todo_license_plate, todo_floor);
    end
  endtask

  task automatic test_single_in();
    pushReq(1'b1, 1'b0, 16'h9423);
    checks++;
    if (todo_exists !== 1'b1 || todo_in !== 1'b1 || todo_out !== 1'b0 || todo_leak_move !== 1'b0) begin
      errors++; $display("[TB] FAIL single_kind got exists=%b in=%b out=%b leak=%b expected 1100",
        todo_exists, todo_in, todo_out, todo_leak_move);
    end
    checks++;
    if (todo_license_plate !== 16'h9423 || queue_count !== 4'd1) begin
      errors++; $display("[TB] FAIL single_data got plate=%h count=%0d expected 9423/1",
        todo_license_plate, queue_count);
    end
    popTask();
    checks++;
    if (todo_exists !== 1'b0 || queue_count !== 4'd0) begin
      errors++; $display("[TB] FAIL single_pop got exists=%b count=%0d expected 0/0",
        todo_exists, queue_count);
    end
  endtask

  task automatic test_order();
    logic [15:0] expPlate [3];
    logic        expIn    [3];
    expPlate[0] = 16'h9423; expIn[0] = 1'b1;
    expPlate[1] = 16'h8754; expIn[1] = 1'b0;
    expPlate[2] = 16'h5755; expIn[2] = 1'b1;
    for (int i = 0; i < 3; i++) pushReq(expIn[i], !expIn[i], expPlate[i]);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (todo_in !== expIn[i] || todo_out !== !expIn[i] || todo_license_plate !== expPlate[i]
          || queue_count !== 4'(3 - i)) begin
        errors++; $display("[TB] FAIL order_%0d got in=%b out=%b plate=%h count=%0d expected in=%b plate=%h count=%0d",
          i, todo_in, todo_out, todo_license_plate, queue_count, expIn[i], expPlate[i], 3 - i);
      end
      popTask();
    end
    checks++;
    if (queue_count !== 4'd0 || todo_exists !== 1'b0) begin
      errors++; $display("[TB] FAIL order_empty got count=%0d exists=%b expected 0/0", queue_count, todo_exists);
    end
  endtask

  task automatic test_leak_priority();
    pushReq(1'b1, 1'b0, 16'h3851);
    leakage = 1'b1; leakage_floor = 3'd5; tick();
    leakage_floor = 3'd2; tick();
    leakage = 1'b0; leakage_floor = 3'd0;
    checks++;
    if (todo_leak_move !== 1'b1 || todo_floor !== 3'd2 || todo_license_plate !== 16'h0
        || todo_in !== 1'b0 || queue_count !== 4'd1) begin
      errors++; $display("[TB] FAIL leak_first got leak=%b floor=%0d plate=%h in=%b count=%0d expected 1/2/0000/0/1",
        todo_leak_move, todo_floor, todo_license_plate, todo_in, queue_count);
    end
    popTask();
    checks++;
    if (todo_leak_move !== 1'b1 || todo_floor !== 3'd5 || queue_count !== 4'd1) begin
      errors++; $display("[TB] FAIL leak_second got leak=%b floor=%0d count=%0d expected 1/5/1",
        todo_leak_move, todo_floor, queue_count);
    end
    popTask();
    checks++;
    if (todo_leak_move !== 1'b0 || todo_in !== 1'b1 || todo_license_plate !== 16'h3851 || todo_floor !== 3'd0) begin
      errors++; $display("[TB] FAIL leak_then_in got leak=%b in=%b plate=%h floor=%0d expected 0/1/3851/0",
        todo_leak_move, todo_in, todo_license_plate, todo_floor);
    end
    popTask();
    checks++;
    if (todo_exists !== 1'b0) begin
      errors++; $display("[TB] FAIL leak_drained got exists=%b expected 0", todo_exists);
    end
  endtask

  task automatic test_reject();
    pushReq(1'b1, 1'b0, 16'h9A22);
    checks++;
    if (reject !== 1'b1 || queue_count !== 4'd0 || todo_exists !== 1'b0) begin
      errors++; $display("[TB] FAIL reject_bcd got reject=%b count=%0d exists=%b expected 1/0/0",
        reject, queue_count, todo_exists);
    end
    tick();
    checks++;
    if (reject !== 1'b0) begin
      errors++; $display("[TB] FAIL reject_pulse got reject=%b expected 0", reject);
    end
    pushReq(1'b1, 1'b1, 16'h9522);
    checks++;
    if (reject !== 1'b1 || queue_count !== 4'd0) begin
      errors++; $display("[TB] FAIL reject_both got reject=%b count=%0d expected 1/0", reject, queue_count);
    end
    pushReq(1'b0, 1'b1, 16'h0000);
    checks++;
    if (reject !== 1'b1 || queue_count !== 4'd0) begin
      errors++; $display("[TB] FAIL reject_zero got reject=%b count=%0d expected 1/0", reject, queue_count);
    end
    leakage = 1'b1; leakage_floor = 3'd0; tick();
    leakage = 1'b0;
    checks++;
    if (reject !== 1'b1 || todo_exists !== 1'b0) begin
      errors++; $display("[TB] FAIL reject_floor0 got reject=%b exists=%b expected 1/0", reject, todo_exists);
    end
    pushReq(1'b0, 1'b1, 16'h0009);
    checks++;
    if (reject !== 1'b0 || queue_count !== 4'd1 || todo_out !== 1'b1) begin
      errors++; $display("[TB] FAIL accept_valid got reject=%b count=%0d out=%b expected 0/1/1",
        reject, queue_count, todo_out);
    end
    popTask();
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 8; i++) pushReq(1'b1, 1'b0, 16'h1000 + 16'(i));
    checks++;
    if (queue_count !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL full_count got count=%0d overflow=%b expected 8/0", queue_count, overflow);
    end
    pushReq(1'b1, 1'b0, 16'h2000);
    checks++;
    if (queue_count !== 4'd8 || overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow_set got count=%0d overflow=%b expected 8/1", queue_count, overflow);
    end
    todo_done = 1'b1;
    pushReq(1'b0, 1'b1, 16'h3000);
    todo_done = 1'b0;
    checks++;
    if (queue_count !== 4'd8 || todo_license_plate !== 16'h1001 || overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL full_push_pop got count=%0d plate=%h overflow=%b expected 8/1001/1",
        queue_count, todo_license_plate, overflow);
    end
    for (int i = 0; i < 7; i++) popTask();
    checks++;
    if (todo_license_plate !== 16'h3000 || todo_out !== 1'b1 || queue_count !== 4'd1) begin
      errors++; $display("[TB] FAIL wrap_tail got plate=%h out=%b count=%0d expected 3000/1/1",
        todo_license_plate, todo_out, queue_count);
    end
    popTask();
    popTask();
    checks++;
    if (overflow !== 1'b1 || todo_exists !== 1'b0 || queue_count !== 4'd0) begin
      errors++; $display("[TB] FAIL overflow_sticky got overflow=%b exists=%b count=%0d expected 1/0/0",
        overflow, todo_exists, queue_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) pushReq(1'b1, 1'b0, 16'h4440 + 16'(i));
    leakage = 1'b1; leakage_floor = 3'd3;
    pushReq(1'b0, 1'b1, 16'h7777);
    leakage = 1'b0; leakage_floor = 3'd0;
    checks++;
    if (queue_count !== 4'd5 || todo_leak_move !== 1'b1 || todo_floor !== 3'd3) begin
      errors++; $display("[TB] FAIL pre_reset got count=%0d leak=%b floor=%0d expected 5/1/3",
        queue_count, todo_leak_move, todo_floor);
    end
    todo_done = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({todo_exists, todo_leak_move, overflow, reject} !== 4'b0 || queue_count !== 4'd0
        || todo_floor !== 3'd0) begin
      errors++; $display("[TB] FAIL async_reset got exists=%b leak=%b overflow=%b count=%0d floor=%0d expected all 0",
        todo_exists, todo_leak_move, overflow, queue_count, todo_floor);
    end
    todo_done = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (todo_exists !== 1'b0 || queue_count !== 4'd0 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset got exists=%b count=%0d overflow=%b expected 0/0/0",
        todo_exists, queue_count, overflow);
    end
  endtask

  initial begin
    reset = 1'b1;
    license_plate = '0; in_mode = 1'b0; out_mode = 1'b0;
    leakage = 1'b0; leakage_floor = '0; todo_done = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_single_in();
    test_order();
    test_leak_priority();
    test_reject();
    test_full_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
